// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: shares one UDP transmit engine between two packet sources.
// Start requests are latched per channel. The engine is granted round-robin,
// one whole packet at a time, and an idle gap is enforced between packets.
// A watchdog aborts a packet whose done pulse never arrives.
module udp_tx_arbiter #(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        eth_tx_clk,
    input  logic        sys_rst,
    input  logic        ch0_tx_start_en,
    input  logic [15:0] ch0_tx_byte_num,
    input  logic [31:0] ch0_tx_data,
    output logic        ch0_tx_req,
    output logic        ch0_tx_done,
    input  logic        ch1_tx_start_en,
    input  logic [15:0] ch1_tx_byte_num,
    input  logic [31:0] ch1_tx_data,
    output logic        ch1_tx_req,
    output logic        ch1_tx_done,
    output logic        udp_tx_start_en,
    output logic [15:0] udp_tx_byte_num,
    output logic [31:0] udp_tx_data,
    input  logic        udp_tx_req,
    input  logic        udp_tx_done,
    output logic        grant,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [19:0] WD_LIMIT = 20'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  pending_q, pending_d;
    logic [15:0] len0_q, len0_d;
    logic [15:0] len1_q, len1_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic [15:0] byte_num_q, byte_num_d;
    logic [19:0] wd_q, wd_d;
    logic [7:0]  gap_q, gap_d;
    logic [1:0]  done_q, done_d;
    logic        timeout_q, timeout_d;
    logic [15:0] drop_q, drop_d;

    logic        owner_s;
    logic [1:0]  drop_inc_s;
    logic [16:0] drop_sum_s;

    // Round-robin owner choice: on a tie the channel not served last wins.
    always_comb begin
        owner_s = 1'b0;
        if (pending_q == 2'b11) begin
            owner_s = ~last_grant_q;
        end else begin
            owner_s = pending_q[1];
        end
    end

    // Next-state logic: request latching, drop counting and the packet FSM.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        len0_d       = len0_q;
        len1_d       = len1_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        byte_num_d   = byte_num_q;
        wd_d         = wd_q;
        gap_d        = gap_q;
        done_d       = 2'b00;
        timeout_d    = 1'b0;
        drop_inc_s   = 2'd0;

        // Channel 0 request: accepted only when nothing is already waiting.
        if (ch0_tx_start_en) begin
            if ((ch0_tx_byte_num != 16'd0) && !pending_q[0]) begin
                pending_d[0] = 1'b1;
                len0_d       = ch0_tx_byte_num;
            end else begin
                drop_inc_s = drop_inc_s + 2'd1;
            end
        end else begin
            len0_d = len0_q;
        end

        // Channel 1 request: same rules as channel 0.
        if (ch1_tx_start_en) begin
            if ((ch1_tx_byte_num != 16'd0) && !pending_q[1]) begin
                pending_d[1] = 1'b1;
                len1_d       = ch1_tx_byte_num;
            end else begin
                drop_inc_s = drop_inc_s + 2'd1;
            end
        end else begin
            len1_d = len1_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    grant_d            = owner_s;
                    byte_num_d         = owner_s ? len1_q : len0_q;
                    pending_d[owner_s] = 1'b0;
                    state_d            = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                last_grant_d = grant_q;
                wd_d         = 20'd0;
                state_d      = ST_BUSY;
            end
            ST_BUSY: begin
                // A real done takes priority over a coincident watchdog expiry.
                if (udp_tx_done) begin
                    done_d[grant_q] = 1'b1;
                    gap_d           = 8'd0;
                    state_d         = ST_GAP;
                end else if (wd_q == WD_LIMIT) begin
                    done_d[grant_q] = 1'b1;
                    timeout_d       = 1'b1;
                    gap_d           = 8'd0;
                    state_d         = ST_GAP;
                end else begin
                    wd_d = wd_q + 20'd1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Saturating drop counter; both channels may drop in one cycle.
        drop_sum_s = {1'b0, drop_q} + {15'd0, drop_inc_s};
        if (drop_sum_s[16]) begin
            drop_d = 16'hFFFF;
        end else begin
            drop_d = drop_sum_s[15:0];
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge eth_tx_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= 2'b00;
            len0_q       <= 16'd0;
            len1_q       <= 16'd0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            byte_num_q   <= 16'd0;
            wd_q         <= 20'd0;
            gap_q        <= 8'd0;
            done_q       <= 2'b00;
            timeout_q    <= 1'b0;
            drop_q       <= 16'd0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            len0_q       <= len0_d;
            len1_q       <= len1_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            byte_num_q   <= byte_num_d;
            wd_q         <= wd_d;
            gap_q        <= gap_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            drop_q       <= drop_d;
        end
    end

    // Status outputs are decoded straight from registered state.
    assign udp_tx_start_en = (state_q == ST_START);
    assign busy            = (state_q == ST_START) || (state_q == ST_BUSY);
    assign grant           = grant_q;
    assign udp_tx_byte_num = byte_num_q;
    assign timeout_err     = timeout_q;
    assign drop_cnt        = drop_q;
    assign ch0_tx_done     = done_q[0];
    assign ch1_tx_done     = done_q[1];

    // Request/data routing is combinational so the engine's req-to-data timing is kept.
    assign ch0_tx_req  = udp_tx_req & busy & (grant_q == 1'b0);
    assign ch1_tx_req  = udp_tx_req & busy & (grant_q == 1'b1);
    assign udp_tx_data = grant_q ? ch1_tx_data : ch0_tx_data;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed testbench for udp_tx_arbiter with hand-computed expectations.
module tb_udp_tx_arbiter;

    localparam int GAP = 16;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        ch0_start, ch1_start;
    logic [15:0] ch0_len, ch1_len;
    logic [31:0] ch0_data, ch1_data;
    logic        ch0_req, ch1_req, ch0_done, ch1_done;
    logic        udp_start;
    logic [15:0] udp_len;
    logic [31:0] udp_data;
    logic        udp_req, udp_done;
    logic        grant, busy, timeout_err;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    udp_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .eth_tx_clk      (clk),
        .sys_rst         (sys_rst),
        .ch0_tx_start_en (ch0_start),
        .ch0_tx_byte_num (ch0_len),
        .ch0_tx_data     (ch0_data),
        .ch0_tx_req      (ch0_req),
        .ch0_tx_done     (ch0_done),
        .ch1_tx_start_en (ch1_start),
        .ch1_tx_byte_num (ch1_len),
        .ch1_tx_data     (ch1_data),
        .ch1_tx_req      (ch1_req),
        .ch1_tx_done     (ch1_done),
        .udp_tx_start_en (udp_start),
        .udp_tx_byte_num (udp_len),
        .udp_tx_data     (udp_data),
        .udp_tx_req      (udp_req),
        .udp_tx_done     (udp_done),
        .grant           (grant),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .drop_cnt        (drop_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        step();
        step();
        sys_rst = 1'b0;
    endtask

    task automatic pulse(input logic s0, input logic [15:0] l0, input logic s1, input logic [15:0] l1);
        ch0_start = s0; ch0_len = l0;
        ch1_start = s1; ch1_len = l1;
        step();
        ch0_start = 1'b0;
        ch1_start = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (udp_start !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (udp_start !== 1'b1) check_eq("start_wait_expired", 32'(udp_start), 32'd1);
    endtask

    // Serve one packet: check grant/length, optionally post requests in BUSY, finish with done.
    task automatic serve(input string tag, input logic exp_g, input logic [15:0] exp_len,
                         input logic r0, input logic [15:0] l0, input logic r1, input logic [15:0] l1);
        int n;
        wait_start(n);
        check_eq({tag, "_grant"}, 32'(grant), 32'(exp_g));
        check_eq({tag, "_len"}, 32'(udp_len), 32'(exp_len));
        step();
        pulse(r0, l0, r1, l1);
        udp_done = 1'b1;
        step();
        udp_done = 1'b0;
        check_eq({tag, "_done0"}, 32'(ch0_done), 32'(exp_g == 1'b0));
        check_eq({tag, "_done1"}, 32'(ch1_done), 32'(exp_g == 1'b1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int n;
        int seen;
        sys_rst = 1'b1;
        ch0_start = 1'b0; ch1_start = 1'b0;
        ch0_len = 16'd0; ch1_len = 16'd0;
        ch0_data = 32'h1111_0000; ch1_data = 32'h2222_0000;
        udp_req = 1'b0; udp_done = 1'b0;
        step();
        do_reset();

        // Reset state
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_start", 32'(udp_start), 32'd0);
        check_eq("rst_drop", 32'(drop_cnt), 32'd0);
        check_eq("rst_done", 32'({ch1_done, ch0_done}), 32'd0);
        check_eq("rst_tmo", 32'(timeout_err), 32'd0);
        udp_req = 1'b1;
        #1;
        check_eq("rst_req_blocked", 32'({ch1_req, ch0_req}), 32'd0);
        udp_req = 1'b0;

        // Single packet on channel 0
        pulse(1'b1, 16'd1024, 1'b0, 16'd0);
        check_eq("t1_start_early", 32'(udp_start), 32'd0);
        step();
        check_eq("t1_start", 32'(udp_start), 32'd1);
        check_eq("t1_len", 32'(udp_len), 32'd1024);
        check_eq("t1_grant", 32'(grant), 32'd0);
        check_eq("t1_busy", 32'(busy), 32'd1);
        step();
        check_eq("t1_start_once", 32'(udp_start), 32'd0);
        udp_req = 1'b1;
        #1;
        check_eq("t1_req0", 32'(ch0_req), 32'd1);
        check_eq("t1_req1", 32'(ch1_req), 32'd0);
        check_eq("t1_data", udp_data, 32'h1111_0000);
        udp_req = 1'b0;
        #1;
        check_eq("t1_req0_low", 32'(ch0_req), 32'd0);
        udp_done = 1'b1;
        step();
        udp_done = 1'b0;
        check_eq("t1_done0", 32'(ch0_done), 32'd1);
        check_eq("t1_done1", 32'(ch1_done), 32'd0);
        check_eq("t1_tmo", 32'(timeout_err), 32'd0);
        check_eq("t1_busy_gap", 32'(busy), 32'd0);
        step();
        check_eq("t1_done_once", 32'(ch0_done), 32'd0);
        // done during GAP must be ignored
        udp_done = 1'b1;
        step();
        udp_done = 1'b0;
        check_eq("t1_done_gap_ignored", 32'({ch1_done, ch0_done}), 32'd0);
        repeat (GAP + 4) step();

        // Simultaneous requests after reset: ch0 then ch1, gap timing
        do_reset();
        pulse(1'b1, 16'd100, 1'b1, 16'd200);
        step();
        check_eq("t2_start_a", 32'(udp_start), 32'd1);
        check_eq("t2_grant_a", 32'(grant), 32'd0);
        check_eq("t2_len_a", 32'(udp_len), 32'd100);
        step();
        udp_done = 1'b1;
        step();
        udp_done = 1'b0;
        check_eq("t2_done_a", 32'(ch0_done), 32'd1);
        repeat (GAP) step();
        check_eq("t2_gap_hold", 32'(udp_start), 32'd0);
        step();
        check_eq("t2_start_b", 32'(udp_start), 32'd1);
        check_eq("t2_grant_b", 32'(grant), 32'd1);
        check_eq("t2_len_b", 32'(udp_len), 32'd200);
        step();
        check_eq("t2_data_b", udp_data, 32'h2222_0000);
        udp_req = 1'b1;
        #1;
        check_eq("t2_req_route", 32'({ch1_req, ch0_req}), 32'd2);
        udp_req = 1'b0;
        udp_done = 1'b1;
        step();
        udp_done = 1'b0;
        check_eq("t2_done_b", 32'({ch1_done, ch0_done}), 32'd2);
        repeat (GAP + 4) step();

        // Fairness: grant order 0,1,0,0
        do_reset();
        pulse(1'b1, 16'd10, 1'b0, 16'd0);
        serve("f1", 1'b0, 16'd10, 1'b1, 16'd11, 1'b1, 16'd21);
        serve("f2", 1'b1, 16'd21, 1'b0, 16'd0, 1'b0, 16'd0);
        serve("f3", 1'b0, 16'd11, 1'b1, 16'd12, 1'b0, 16'd0);
        serve("f4", 1'b0, 16'd12, 1'b0, 16'd0, 1'b0, 16'd0);
        repeat (GAP + 4) step();

        // Drops: repeated starts while pending and a zero-length start
        do_reset();
        pulse(1'b1, 16'd50, 1'b0, 16'd0);
        wait_start(n);
        step();
        pulse(1'b0, 16'd0, 1'b1, 16'd300);
        pulse(1'b0, 16'd0, 1'b1, 16'd301);
        pulse(1'b0, 16'd0, 1'b1, 16'd302);
        pulse(1'b0, 16'd0, 1'b1, 16'd0);
        check_eq("d_drop3", 32'(drop_cnt), 32'd3);
        pulse(1'b1, 16'd0, 1'b1, 16'd303);
        check_eq("d_drop_both", 32'(drop_cnt), 32'd5);
        udp_done = 1'b1;
        step();
        udp_done = 1'b0;
        check_eq("d_done0", 32'(ch0_done), 32'd1);
        serve("d2", 1'b1, 16'd300, 1'b0, 16'd0, 1'b0, 16'd0);
        seen = 0;
        for (int i = 0; i < GAP + 30; i++) begin
            step();
            if (udp_start === 1'b1) seen++;
        end
        check_eq("d_no_extra_start", 32'(seen), 32'd0);

        // Watchdog abort after 64 BUSY cycles, then serve queued ch1
        do_reset();
        pulse(1'b1, 16'd64, 1'b0, 16'd0);
        wait_start(n);
        step();
        pulse(1'b0, 16'd0, 1'b1, 16'd99);
        repeat (62) step();
        check_eq("w_no_tmo_yet", 32'(timeout_err), 32'd0);
        check_eq("w_busy_64", 32'(busy), 32'd1);
        step();
        check_eq("w_tmo", 32'(timeout_err), 32'd1);
        check_eq("w_done0", 32'(ch0_done), 32'd1);
        check_eq("w_done1", 32'(ch1_done), 32'd0);
        check_eq("w_busy_off", 32'(busy), 32'd0);
        step();
        check_eq("w_tmo_once", 32'(timeout_err), 32'd0);
        wait_start(n);
        check_eq("w_gap_len", 32'(n), 32'(GAP));
        check_eq("w_grant1", 32'(grant), 32'd1);
        check_eq("w_len1", 32'(udp_len), 32'd99);
        step();
        udp_done = 1'b1;
        step();
        udp_done = 1'b0;
        check_eq("w_done_b", 32'({ch1_done, ch0_done}), 32'd2);
        check_eq("w_tmo_b", 32'(timeout_err), 32'd0);
        repeat (GAP + 4) step();

        // Reset mid-packet
        do_reset();
        pulse(1'b1, 16'd40, 1'b0, 16'd0);
        wait_start(n);
        step();
        pulse(1'b0, 16'd0, 1'b1, 16'd55);
        pulse(1'b0, 16'd0, 1'b1, 16'd56);
        check_eq("r_drop_pre", 32'(drop_cnt), 32'd1);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        check_eq("r_busy", 32'(busy), 32'd0);
        check_eq("r_done", 32'({ch1_done, ch0_done}), 32'd0);
        check_eq("r_drop", 32'(drop_cnt), 32'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (udp_start === 1'b1 || ch0_done === 1'b1 || ch1_done === 1'b1) seen++;
        end
        check_eq("r_pending_cleared", 32'(seen), 32'd0);
        pulse(1'b0, 16'd0, 1'b1, 16'd77);
        wait_start(n);
        check_eq("r_latency", 32'(n), 32'd1);
        check_eq("r_grant", 32'(grant), 32'd1);
        check_eq("r_len", 32'(udp_len), 32'd77);
        step();
        udp_done = 1'b1;
        step();
        udp_done = 1'b0;
        check_eq("r_done_b", 32'({ch1_done, ch0_done}), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
